// File: rtl/arm_multicycle_core_if.sv
// Unified instruction/data memory port: the core requests, memory completes with ready.
interface arm_multicycle_core_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/arm_multicycle_core.sv
// Multicycle ARM subset core: conditional DP, LDR/STR (imm offset), B/BL over one
// shared memory port that may insert wait states.
module arm_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arm_multicycle_core_if.master mem,
  output logic [31:0]           pc,
  output logic [31:0]           instr,
  output logic [3:0]            flags,
  output logic                  retire
);

  typedef enum logic [3:0] {
    START, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWR, MEMWB, BRANCH
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, instr_reg, a_reg, b_reg, res_reg, addr_reg, data_reg;
  logic [3:0]  flags_reg;
  logic        c_alu_reg, v_alu_reg;
  logic [31:0] regs [0:14];

  logic [3:0]  cond, cmd, rn, rd, rm, b_idx;
  logic [1:0]  op;
  logic        imm_i, s_bit, up, load, link;
  logic [7:0]  imm8;
  logic [11:0] imm12;
  logic [23:0] imm24;

  assign cond  = instr_reg[31:28];
  assign op    = instr_reg[27:26];
  assign imm_i = instr_reg[25];
  assign cmd   = instr_reg[24:21];
  assign link  = instr_reg[24];
  assign up    = instr_reg[23];
  assign s_bit = instr_reg[20];
  assign load  = instr_reg[20];
  assign rn    = instr_reg[19:16];
  assign rd    = instr_reg[15:12];
  assign rm    = instr_reg[3:0];
  assign imm8  = instr_reg[7:0];
  assign imm12 = instr_reg[11:0];
  assign imm24 = instr_reg[23:0];

  // Second read port serves Rm for data processing and Rd (store data) for memory ops.
  logic [31:0] pc_plus4, a_val, b_val;
  assign pc_plus4 = pc_reg + 32'd4;
  assign b_idx    = (op == 2'b01) ? rd : rm;
  assign a_val    = (rn == 4'd15) ? pc_plus4 : regs[rn];
  assign b_val    = (b_idx == 4'd15) ? pc_plus4 : regs[b_idx];

  logic is_add, is_sub, is_cmp, is_orr, is_arith;
  assign is_cmp   = (cmd == 4'b1010);
  assign is_add   = (cmd == 4'b0100);
  assign is_sub   = (cmd == 4'b0010) || is_cmp;
  assign is_orr   = (cmd == 4'b1100);
  assign is_arith = is_add || is_sub;

  logic [32:0] sum33, diff33;
  logic [31:0] alu_res;
  logic        alu_c, alu_v;
  assign sum33  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff33 = {1'b0, a_reg} + {1'b0, ~b_reg} + 33'd1;

  always_comb begin
    alu_res = a_reg & b_reg;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (is_add) begin
      alu_res = sum33[31:0];
      alu_c   = sum33[32];
      alu_v   = (a_reg[31] == b_reg[31]) && (alu_res[31] != a_reg[31]);
    end else if (is_sub) begin
      alu_res = diff33[31:0];
      alu_c   = diff33[32];
      alu_v   = (a_reg[31] != b_reg[31]) && (alu_res[31] != a_reg[31]);
    end else if (is_orr) begin
      alu_res = a_reg | b_reg;
    end
  end

  logic cond_pass, fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_reg;
  always_comb begin
    case (cond)
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = !fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = !fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = !fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = !fv;
      4'b1000: cond_pass = fc && !fz;
      4'b1001: cond_pass = !fc || fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = !fz && (fn == fv);
      4'b1101: cond_pass = fz || (fn != fv);
      default: cond_pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= START;
    else        state_reg <= state_next;
  end

  logic        req_c, we_c, retire_c, rf_we, flags_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    state_next = state_reg;
    req_c      = 1'b0;
    we_c       = 1'b0;
    retire_c   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = res_reg;
    flags_we   = 1'b0;
    case (state_reg)
      START:  state_next = FETCH;
      FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        if (!cond_pass || op == 2'b11) begin
          retire_c   = 1'b1;
          state_next = FETCH;
        end else if (op == 2'b00) state_next = EXEC;
        else if (op == 2'b01)     state_next = MEMADR;
        else                      state_next = BRANCH;
      end
      EXEC:   state_next = ALUWB;
      ALUWB: begin
        rf_we      = !is_cmp;
        flags_we   = s_bit || is_cmp;
        retire_c   = 1'b1;
        state_next = FETCH;
      end
      MEMADR: state_next = load ? MEMRD : MEMWR;
      MEMRD: begin
        req_c = 1'b1;
        if (mem.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        rf_we      = 1'b1;
        rf_wdata   = data_reg;
        retire_c   = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        if (mem.mem_ready) begin
          retire_c   = 1'b1;
          state_next = FETCH;
        end
      end
      BRANCH: begin
        rf_we      = link;
        rf_waddr   = 4'd14;
        rf_wdata   = pc_reg;
        retire_c   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      flags_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      c_alu_reg <= 1'b0;
      v_alu_reg <= 1'b0;
    end else begin
      if (state_reg == FETCH && mem.mem_ready) begin
        instr_reg <= mem.mem_rdata;
        pc_reg    <= pc_plus4;
      end
      if (state_reg == DECODE) begin
        a_reg <= a_val;
        b_reg <= (op == 2'b00 && imm_i) ? {24'd0, imm8} : b_val;
      end
      if (state_reg == EXEC) begin
        res_reg   <= alu_res;
        c_alu_reg <= alu_c;
        v_alu_reg <= alu_v;
      end
      if (state_reg == MEMADR)
        addr_reg <= up ? a_reg + {20'd0, imm12} : a_reg - {20'd0, imm12};
      if (state_reg == MEMRD && mem.mem_ready) data_reg <= mem.mem_rdata;
      // pc here already points at the next instruction, so target = fetch + 8 + offset.
      if (state_reg == BRANCH) pc_reg <= pc_plus4 + {{6{imm24[23]}}, imm24, 2'b00};
      if (rf_we && rf_waddr == 4'd15) pc_reg <= rf_wdata;
      if (flags_we)
        flags_reg <= {res_reg[31], res_reg == 32'd0,
                      is_arith ? c_alu_reg : flags_reg[1],
                      is_arith ? v_alu_reg : flags_reg[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (rf_we && rf_waddr != 4'd15) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  logic [31:0] addr_full;
  assign addr_full     = (state_reg == MEMRD || state_reg == MEMWR) ? addr_reg : pc_reg;
  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_full[ADDR_W-1:0];
  assign mem.mem_wdata = b_reg;

  assign pc     = pc_reg;
  assign instr  = instr_reg;
  assign flags  = flags_reg;
  assign retire = retire_c;

endmodule

// File: tb/tb_arm_multicycle_core.sv
// Scoreboard bench: expected bus transfers and retire latencies/flags are queued per program.
module tb_arm_multicycle_core;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, instr;
  logic [3:0]  flags;
  logic        retire;

  arm_multicycle_core_if #(.ADDR_W(32)) mem_bus ();

  arm_multicycle_core #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem    (mem_bus),
    .pc     (pc),
    .instr  (instr),
    .flags  (flags),
    .retire (retire)
  );

  always #5 clk = ~clk;

  // Memory model: programs in rom (bench-loaded), data region in ram (bus-written).
  logic [31:0] rom [0:255];
  logic [31:0] ram [0:255];
  int          prog_waits = 0, data_waits = 0, wait_cnt;
  logic        in_data;

  assign in_data = (mem_bus.mem_addr < 32'h20) || (mem_bus.mem_addr >= 32'h200);
  assign mem_bus.mem_rdata = in_data ? ram[mem_bus.mem_addr[9:2]] : rom[mem_bus.mem_addr[9:2]];
  assign mem_bus.mem_ready = mem_bus.mem_req && (wait_cnt >= (in_data ? data_waits : prog_waits));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (mem_bus.mem_req && mem_bus.mem_ready) begin
      wait_cnt <= 0;
      if (mem_bus.mem_we) ram[mem_bus.mem_addr[9:2]] <= mem_bus.mem_wdata;
    end else if (mem_bus.mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int lat; logic [3:0] flags; } ret_t;
  bus_t exp_bus[$];
  ret_t exp_ret[$];

  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transaction monitor, sampled on the falling edge.
  int          cyc = 0, last_ret = 0;
  logic        req_prev = 1'b0, hs_prev = 1'b0;
  logic [31:0] addr_prev, wdata_prev;
  logic [3:0]  flag_exp = 4'd0;
  bus_t        b_pop;
  ret_t        r_pop;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_ret = cyc;
      req_prev = 1'b0;
      hs_prev  = 1'b0;
      flag_exp = 4'd0;
    end else begin
      if (mem_bus.mem_req && req_prev && !hs_prev) begin
        check("addr_stable", mem_bus.mem_addr, addr_prev);
        check("wdata_stable", mem_bus.mem_wdata, wdata_prev);
      end
      if (retire) begin
        check("retire_expected", 32'(exp_ret.size() > 0), 32'd1);
        check("flags", {28'd0, flags}, {28'd0, flag_exp});
        if (exp_ret.size() > 0) begin
          r_pop = exp_ret.pop_front();
          check("retire_latency", 32'(cyc - last_ret), 32'(r_pop.lat));
          $display("[TB] retire cycle %0d latency %0d pc 0x%08h", cyc, cyc - last_ret, pc);
          flag_exp = r_pop.flags;
        end
        last_ret = cyc;
      end
      if (mem_bus.mem_req && mem_bus.mem_ready) begin
        check("bus_expected", 32'(exp_bus.size() > 0), 32'd1);
        if (exp_bus.size() > 0) begin
          b_pop = exp_bus.pop_front();
          check("bus_we", {31'd0, mem_bus.mem_we}, {31'd0, b_pop.we});
          check("bus_addr", mem_bus.mem_addr, b_pop.addr);
          if (b_pop.we) check("bus_wdata", mem_bus.mem_wdata, b_pop.data);
          $display("[TB] bus %s addr 0x%08h data 0x%08h", mem_bus.mem_we ? "WR" : "RD",
                   mem_bus.mem_addr, mem_bus.mem_we ? mem_bus.mem_wdata : mem_bus.mem_rdata);
        end
      end
      req_prev   = mem_bus.mem_req;
      hs_prev    = mem_bus.mem_req && mem_bus.mem_ready;
      addr_prev  = mem_bus.mem_addr;
      wdata_prev = mem_bus.mem_wdata;
    end
  end

  function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] cm,
                                     input logic s, input logic [3:0] n, input logic [3:0] d,
                                     input logic [11:0] op2);
    return {c, 2'b00, i, cm, s, n, d, op2};
  endfunction

  function automatic logic [31:0] ls(input logic [3:0] c, input logic l, input logic [3:0] n,
                                     input logic [3:0] d, input logic [11:0] off);
    return {c, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l, n, d, off};
  endfunction

  function automatic logic [31:0] br(input logic [3:0] c, input logic l, input logic [23:0] off);
    return {c, 3'b101, l, off};
  endfunction

  task automatic ins(input logic [31:0] a, input logic [31:0] w, input int lat, input logic [3:0] f);
    bus_t b;
    ret_t r;
    rom[a[9:2]] = w;
    b.we = 1'b0; b.addr = a; b.data = '0;
    exp_bus.push_back(b);
    r.lat = lat; r.flags = f;
    exp_ret.push_back(r);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_t b;
    b.we = we; b.addr = a; b.data = d;
    exp_bus.push_back(b);
  endtask

  task automatic run_prog(input int budget);
    int guard;
    @(negedge clk);
    #1 rst_n = 1'b1;
    check("start_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
    @(negedge clk);
    check("first_fetch_req", {31'd0, mem_bus.mem_req}, 32'd1);
    check("first_fetch_addr", mem_bus.mem_addr, RST_PC);
    guard = 0;
    while (exp_ret.size() != 0 && guard < budget) begin
      @(posedge clk);
      guard++;
    end
    #1 rst_n = 1'b0;
    check("program_done", 32'(guard < budget), 32'd1);
    check("bus_leftover", 32'(exp_bus.size()), 32'd0);
    exp_bus.delete();
    exp_ret.delete();
    @(negedge clk);
  endtask

  localparam logic [3:0] AL = 4'hE, EQ = 4'h0, NE = 4'h1;
  localparam logic [3:0] ADD = 4'b0100, SUB = 4'b0010, ORR = 4'b1100, CMP = 4'b1010;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1);
  end

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pc", pc, RST_PC);
    check("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_bus.mem_we}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_addr", mem_bus.mem_addr, RST_PC);
    check("rst_wdata", mem_bus.mem_wdata, 32'd0);

    // Data processing with flags
    ins(32'h100, dp(AL, 1, ADD, 1, 4'd0, 4'd1, 12'h0FF), 4, 4'b0000);
    ins(32'h104, dp(AL, 1, SUB, 1, 4'd1, 4'd2, 12'h0FF), 4, 4'b0110);
    ins(32'h108, ls(AL, 0, 4'd0, 4'd1, 12'h200), 4, 4'b0110);
    push_bus(1, 32'h200, 32'h0000_00FF);
    ins(32'h10C, ls(AL, 0, 4'd0, 4'd2, 12'h204), 4, 4'b0110);
    push_bus(1, 32'h204, 32'h0);
    run_prog(200);

    // Conditional execution, CMP with S=0, borrow and logical flag behaviour
    ins(32'h100, dp(AL, 1, CMP, 0, 4'd0, 4'd5, 12'h000), 4, 4'b0110);
    ins(32'h104, dp(NE, 1, ADD, 0, 4'd3, 4'd3, 12'h001), 2, 4'b0110);
    ins(32'h108, dp(EQ, 1, ADD, 0, 4'd5, 4'd5, 12'h001), 4, 4'b0110);
    ins(32'h10C, ls(AL, 0, 4'd0, 4'd3, 12'h200), 4, 4'b0110);
    push_bus(1, 32'h200, 32'h0);
    ins(32'h110, ls(AL, 0, 4'd0, 4'd5, 12'h204), 4, 4'b0110);
    push_bus(1, 32'h204, 32'h1);
    ins(32'h114, dp(AL, 1, SUB, 1, 4'd5, 4'd6, 12'h002), 4, 4'b1000);
    ins(32'h118, dp(AL, 1, ADD, 1, 4'd6, 4'd7, 12'h001), 4, 4'b0110);
    ins(32'h11C, dp(AL, 1, ORR, 1, 4'd6, 4'd8, 12'h000), 4, 4'b1010);
    ins(32'h120, ls(AL, 0, 4'd0, 4'd8, 12'h208), 4, 4'b1010);
    push_bus(1, 32'h208, 32'hFFFF_FFFF);
    run_prog(300);

    // Memory with 3 wait cycles per transfer
    prog_waits = 3;
    data_waits = 3;
    ins(32'h100, dp(AL, 1, ADD, 0, 4'd0, 4'd1, 12'h0FF), 7, 4'b0000);
    ins(32'h104, ls(AL, 0, 4'd0, 4'd1, 12'h008), 10, 4'b0000);
    push_bus(1, 32'h008, 32'h0000_00FF);
    ins(32'h108, ls(AL, 1, 4'd0, 4'd4, 12'h008), 11, 4'b0000);
    push_bus(0, 32'h008, 32'h0);
    ins(32'h10C, ls(AL, 0, 4'd0, 4'd4, 12'h200), 10, 4'b0000);
    push_bus(1, 32'h200, 32'h0000_00FF);
    run_prog(300);
    prog_waits = 0;
    data_waits = 0;

    // PC write, BL, R15 read, backward branch to self
    ins(32'h100, dp(AL, 1, ADD, 0, 4'd0, 4'd15, 12'h020), 4, 4'b0000);
    ins(32'h020, br(AL, 1, 24'h000002), 3, 4'b0000);
    ins(32'h030, ls(AL, 0, 4'd0, 4'd14, 12'h200), 4, 4'b0000);
    push_bus(1, 32'h200, 32'h0000_0024);
    ins(32'h034, ls(AL, 0, 4'd0, 4'd15, 12'h204), 4, 4'b0000);
    push_bus(1, 32'h204, 32'h0000_003C);
    for (int k = 0; k < 3; k++) ins(32'h038, br(AL, 0, 24'hFFFFFE), 3, 4'b0000);
    run_prog(300);

    // Reset during a stalled MEMRD
    data_waits = 1000;
    rom[32'h100 >> 2] = ls(AL, 1, 4'd0, 4'd4, 12'h010);
    push_bus(0, 32'h100, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    guard = 0;
    while (!(mem_bus.mem_req && mem_bus.mem_addr == 32'h10) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("memrd_reached", 32'(guard < 50), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("midrst_pc", pc, RST_PC);
    check("midrst_addr", mem_bus.mem_addr, RST_PC);
    check("midrst_retire", {31'd0, retire}, 32'd0);
    check("midrst_bus_left", 32'(exp_bus.size()), 32'd0);
    exp_bus.delete();
    exp_ret.delete();
    data_waits = 0;
    ins(32'h100, ls(AL, 0, 4'd0, 4'd4, 12'h200), 4, 4'b0000);
    push_bus(1, 32'h200, 32'h0);
    run_prog(200);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
